parking_tick_scheduler: RTL

- Generates one shared 1 Hz timebase from the system clock as a single-cycle enable pulse, not a divided clock.
- Shares that timebase among NUM_CH countdown timer channels (gate-open hold, barrier timeout, display blink, occupancy poll).
- Requesters load durations through a single round-robin-arbitrated load port, one load per cycle.
- Each channel counts down on the shared tick and reports expiry as a one-cycle done pulse.

---
 rtl/parking_tick_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/parking_tick_scheduler.sv
// Shared 1 Hz tick generator feeding NUM_CH countdown timers.
// Durations are loaded through a round-robin arbitrated port.
module parking_tick_scheduler #(
  parameter int unsigned INPUT_CLOCK_FREQ = 40_000_000,
  parameter int unsigned TICK_DIV         = INPUT_CLOCK_FREQ,
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned CNT_W            = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*CNT_W-1:0]   dur,
  input  logic [NUM_CH-1:0]         cancel,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel,
  output logic [NUM_CH-1:0]         grant,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic                      tick,
  output logic [CNT_W-1:0]          rd_remaining
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);
  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]             r_presc;
  logic                         r_tick;
  logic                         w_presc_wrap;
  logic [SEL_W-1:0]             r_ptr;
  logic [NUM_CH-1:0]            r_grant;
  logic [NUM_CH-1:0]            r_busy;
  logic [NUM_CH-1:0]            r_done;
  logic [NUM_CH-1:0][CNT_W-1:0] r_rem;

  logic [NUM_CH-1:0][CNT_W-1:0] w_dur;
  logic [NUM_CH-1:0]            w_elig;
  logic                         w_found;
  logic [SEL_W-1:0]             w_win;
  logic [NUM_CH-1:0]            w_grant_d;
  logic [NUM_CH-1:0]            w_busy_d;
  logic [NUM_CH-1:0]            w_done_d;
  logic [NUM_CH-1:0][CNT_W-1:0] w_rem_d;

  assign w_dur        = dur;
  assign w_presc_wrap = (r_presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_wrap ? '0 : r_presc + PRE_W'(1);
      r_tick  <= w_presc_wrap;
    end
  end

  // Round-robin search upward from the pointer; NUM_CH is a power of two so
  // the index wraps by truncation.
  always_comb begin
    w_elig  = req & ~r_busy & ~cancel;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      if (!w_found && w_elig[r_ptr + SEL_W'(off)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + SEL_W'(off);
      end
    end
  end

  always_comb begin
    w_busy_d  = r_busy;
    w_rem_d   = r_rem;
    w_done_d  = '0;
    w_grant_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cancel[ch]) begin
        w_busy_d[ch] = 1'b0;
        w_rem_d[ch]  = '0;
      end else if (r_busy[ch] && r_tick) begin
        if (r_rem[ch] == CNT_W'(1)) begin
          w_busy_d[ch] = 1'b0;
          w_rem_d[ch]  = '0;
          w_done_d[ch] = 1'b1;
        end else begin
          w_rem_d[ch] = r_rem[ch] - CNT_W'(1);
        end
      end
    end
    // The winner is idle and not cancelled, so the load never collides with
    // countdown or cancel of the same channel.
    if (w_found) begin
      w_grant_d[w_win] = 1'b1;
      w_rem_d[w_win]   = w_dur[w_win];
      w_busy_d[w_win]  = (w_dur[w_win] != '0);
      w_done_d[w_win]  = (w_dur[w_win] == '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_busy  <= '0;
      r_done  <= '0;
      r_rem   <= '0;
    end else begin
      if (w_found) begin
        r_ptr <= w_win + SEL_W'(1);
      end
      r_grant <= w_grant_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_rem   <= w_rem_d;
    end
  end

  assign grant        = r_grant;
  assign busy         = r_busy;
  assign done         = r_done;
  assign tick         = r_tick;
  assign rd_remaining = r_rem[rd_sel];

endmodule
